load_store_unit: RTL

- Sits directly upstream of the word-addressed data memory and is the CPU memory stage's only path to it.
- Accepts byte, halfword and word load/store requests over a valid/ready handshake.
- Converts sub-word stores into a read-modify-write of the containing word.
- Extracts and sign- or zero-extends load data, and flags out-of-range (and optionally misaligned) accesses.

---
 rtl/load_store_unit.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// The memory stage's only path to the word-addressed data memory.
// - Loads: reads the containing word, picks out the byte/half lane and
//   sign- or zero-extends it.
// - Word stores: write the latched data directly.
// - Byte/half stores: read-modify-write of the containing word.
// - Out-of-range word indices return an error and never touch memory.
//
// Optional build macro:
//   MISALIGN_TRAP_EN - when defined, misaligned halves (addr[0]=1) and words
//   (addr[1:0]!=0) return an error without a memory access. When undefined,
//   the low address bits below the access size are ignored.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   req_valid       request present
//   req_ready       unit is idle and accepts a request this cycle
//   req_write       1 = store, 0 = load
//   req_size        00 byte, 01 half, 10/11 word
//   req_signed      load extension: 1 = sign, 0 = zero
//   req_addr        byte address
//   req_wdata       right-aligned store data
//   resp_valid      one-cycle completion pulse
//   resp_rdata      extended load data (0 for stores and errors)
//   resp_err        range or (optionally) alignment error
//   mem_addr        word-aligned byte address to memory (0 when idle)
//   mem_write_data  word to write
//   mem_write       one-cycle write strobe
//   mem_read_data   combinational memory read data
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int MEM_WORDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic        mem_write,
    input  logic [31:0] mem_read_data
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_RMW_RD = 3'd2;
    localparam logic [2:0] S_WRITE  = 3'd3;
    localparam logic [2:0] S_RESP   = 3'd4;

    localparam logic [31:0] LP_WORDS = 32'(MEM_WORDS);

    // Lane extraction with extension; sizes 10 and 11 pass the word through.
    function automatic logic [31:0] f_extract(input logic [31:0] word,
                                              input logic [1:0]  size,
                                              input logic [1:0]  off,
                                              input logic        sgn);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{off, 3'b000} +: 8];
        h = word[{off[1], 4'b0000} +: 16];
        case (size)
            2'b00:   f_extract = sgn ? {{24{b[7]}}, b} : {24'd0, b};
            2'b01:   f_extract = sgn ? {{16{h[15]}}, h} : {16'd0, h};
            default: f_extract = word;
        endcase
    endfunction

    // Replace the addressed lane of the old word with the new store data.
    function automatic logic [31:0] f_merge(input logic [31:0] word,
                                            input logic [31:0] wdata,
                                            input logic [1:0]  size,
                                            input logic [1:0]  off);
        logic [31:0] r;
        r = word;
        case (size)
            2'b00:   r[{off, 3'b000} +: 8]     = wdata[7:0];
            2'b01:   r[{off[1], 4'b0000} +: 16] = wdata[15:0];
            default: r = wdata;
        endcase
        f_merge = r;
    endfunction

    logic [2:0]  r_state;
    logic        r_err;
    logic [31:0] r_addr;
    logic [1:0]  r_size;
    logic        r_signed;
    logic [31:0] r_wdata;
    logic [31:0] r_merge;
    logic [31:0] r_rdata;

    logic        w_range_err;
    logic        w_misalign;
    logic        w_err;
    logic        w_mem_access;

    assign w_range_err = {2'b00, req_addr[31:2]} >= LP_WORDS;

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((req_size == 2'b01) && req_addr[0]) ||
                        (req_size[1] && (req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    assign w_err = w_range_err | w_misalign;

    // Control state: the only registers that see reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_err <= w_err;
                        if (w_err)
                            r_state <= S_RESP;
                        else if (!req_write)
                            r_state <= S_LOAD;
                        else if (req_size[1])
                            r_state <= S_WRITE;
                        else
                            r_state <= S_RMW_RD;
                    end
                end
                S_LOAD:   r_state <= S_RESP;
                S_RMW_RD: r_state <= S_WRITE;
                S_WRITE:  r_state <= S_RESP;
                S_RESP:   r_state <= S_IDLE;
                default:  r_state <= S_IDLE;
            endcase
        end
    end

    // Datapath registers; every output using them is masked by the state,
    // so they need no reset.
    always_ff @(posedge clk) begin
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    r_addr   <= req_addr;
                    r_size   <= req_size;
                    r_signed <= req_signed;
                    r_wdata  <= req_wdata;
                    r_rdata  <= 32'd0;
                end
            end
            S_LOAD:   r_rdata <= f_extract(mem_read_data, r_size, r_addr[1:0], r_signed);
            S_RMW_RD: r_merge <= mem_read_data;
            default:  ;
        endcase
    end

    assign w_mem_access = (r_state == S_LOAD) || (r_state == S_RMW_RD) ||
                          (r_state == S_WRITE);

    // All outputs decode from the state so a reset clears them immediately,
    // including the write strobe of an interrupted read-modify-write.
    assign req_ready      = (r_state == S_IDLE);
    assign resp_valid     = (r_state == S_RESP);
    assign resp_rdata     = (r_state == S_RESP) ? r_rdata : 32'd0;
    assign resp_err       = (r_state == S_RESP) ? r_err : 1'b0;
    assign mem_addr       = w_mem_access ? {r_addr[31:2], 2'b00} : 32'd0;
    assign mem_write      = (r_state == S_WRITE);
    assign mem_write_data = (r_state == S_WRITE) ?
                            f_merge(r_merge, r_wdata, r_size, r_addr[1:0]) : 32'd0;

endmodule
